// File: rtl/fcc.sv
// Fully-connected layer engine: z[r] = sat8((x . W[r] + b[r]) >>> 8), one output row at a time.
// Optional build macro FCC_RELU_EN clamps negative results to zero before they are written.
module fcc #(
  parameter int ADDR_WIDTH  = 19,
  parameter int CHUNK_BYTES = 32,
  parameter int DIM_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fc_go,
  input  logic [ADDR_WIDTH-1:0]      fc_addrx,
  input  logic [ADDR_WIDTH-1:0]      fc_addry,
  input  logic [ADDR_WIDTH-1:0]      fc_addrb,
  input  logic [ADDR_WIDTH-1:0]      fc_addrz,
  input  logic [DIM_W-1:0]           fc_xm,
  input  logic [DIM_W-1:0]           fc_ym,
  input  logic [DIM_W-1:0]           fc_yn,
  input  logic [DIM_W-1:0]           cnn_bn,
  output logic                       fc_sw_busy_ind,
  output logic                       fc_done,
  output logic                       pic_mem_req,
  output logic [ADDR_WIDTH-1:0]      pic_mem_start_addr,
  output logic [5:0]                 pic_mem_size_bytes,
  input  logic                       pic_mem_valid,
  input  logic [CHUNK_BYTES*8-1:0]   pic_mem_data,
  input  logic                       pic_last,
  input  logic [4:0]                 pic_mem_last_valid,
  output logic                       wgt_mem_req,
  output logic [ADDR_WIDTH-1:0]      wgt_mem_start_addr,
  output logic [5:0]                 wgt_mem_size_bytes,
  input  logic                       wgt_mem_valid,
  input  logic [CHUNK_BYTES*8-1:0]   wgt_mem_data,
  input  logic                       wgt_last,
  input  logic [4:0]                 wgt_mem_last_valid,
  output logic                       bias_mem_req,
  output logic [ADDR_WIDTH-1:0]      bias_mem_start_addr,
  output logic [5:0]                 bias_mem_size_bytes,
  input  logic                       bias_mem_valid,
  input  logic [CHUNK_BYTES*8-1:0]   bias_mem_data,
  input  logic                       bias_last,
  input  logic [4:0]                 bias_mem_last_valid,
  output logic                       wr_mem_req,
  output logic [ADDR_WIDTH-1:0]      wr_mem_start_addr,
  output logic [5:0]                 wr_mem_size_bytes,
  output logic [CHUNK_BYTES*8-1:0]   wr_mem_data,
  output logic                       wr_last,
  output logic [4:0]                 wr_mem_last_valid,
  input  logic                       wr_mem_ack
);

  localparam int DW = CHUNK_BYTES * 8;
  localparam int CW = DIM_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_DATA, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addrx_q, addrx_d, addrb_q, addrb_d, addrz_q, addrz_d;
  logic [ADDR_WIDTH-1:0]   wrow_q, wrow_d;
  logic [DIM_W-1:0]        ym_q, ym_d, yn_q, yn_d, bn_q, bn_d, row_q, row_d;
  logic [CW-1:0]           cofs_q, cofs_d;
  logic signed [31:0]      acc_q, acc_d;
  logic [DW-1:0]           pic_buf_q, pic_buf_d, wgt_buf_q, wgt_buf_d;
  logic                    pic_got_q, pic_got_d, wgt_got_q, wgt_got_d;
  logic [7:0]              res_q, res_d;
  logic [CW-1:0]           rem_w, chunk_sz_w;
  logic                    bias_need_w;

  // Sum of byte-wise signed products over the valid lanes of one beat.
  function automatic logic signed [31:0] mac_chunk(input logic [DW-1:0] p, input logic [DW-1:0] w,
                                                   input logic [CW-1:0] n);
    logic signed [31:0] s;
    logic signed [7:0]  a, b;
    logic signed [15:0] m;
    s = '0;
    for (int i = 0; i < CHUNK_BYTES; i++) begin
      a = p[8*i +: 8];
      b = w[8*i +: 8];
      m = a * b;
      if (CW'(i) < n) s = s + {{16{m[15]}}, m};
    end
    return s;
  endfunction

  function automatic logic [7:0] to_byte(input logic signed [31:0] acc);
    logic signed [31:0] sh;
    logic [7:0]         r;
    sh = acc >>> 8;
    if (sh > 32'sd127)       r = 8'h7f;
    else if (sh < -32'sd128) r = 8'h80;
    else                     r = sh[7:0];
`ifdef FCC_RELU_EN
    if (r[7]) r = 8'h00;
`endif
    return r;
  endfunction

  assign rem_w       = {1'b0, yn_q} - cofs_q;
  assign chunk_sz_w  = (rem_w >= CW'(CHUNK_BYTES)) ? CW'(CHUNK_BYTES) : rem_w;
  assign bias_need_w = (row_q < bn_q);

  assign fc_sw_busy_ind      = (state_q != S_IDLE);
  assign fc_done             = (state_q == S_DONE);
  assign pic_mem_req         = (state_q == S_DATA) && !pic_got_q;
  assign wgt_mem_req         = (state_q == S_DATA) && !wgt_got_q;
  assign pic_mem_start_addr  = addrx_q + ADDR_WIDTH'(cofs_q);
  assign wgt_mem_start_addr  = wrow_q + ADDR_WIDTH'(cofs_q);
  assign pic_mem_size_bytes  = (state_q == S_DATA) ? chunk_sz_w[5:0] : 6'd0;
  assign wgt_mem_size_bytes  = pic_mem_size_bytes;
  assign bias_mem_req        = (state_q == S_BIAS) && bias_need_w;
  assign bias_mem_start_addr = addrb_q + ADDR_WIDTH'(row_q);
  assign bias_mem_size_bytes = bias_mem_req ? 6'd1 : 6'd0;
  assign wr_mem_req          = (state_q == S_WRITE);
  assign wr_mem_start_addr   = addrz_q + ADDR_WIDTH'(row_q);
  assign wr_mem_size_bytes   = wr_mem_req ? 6'd1 : 6'd0;
  assign wr_last             = wr_mem_req;
  assign wr_mem_last_valid   = 5'd0;
  assign wr_mem_data         = {{(DW-8){1'b0}}, res_q};

  // Inputs with no role here: fc_xm duplicates fc_yn, and read-side last flags are redundant with size.
  logic unused_inputs;
  assign unused_inputs = ^{fc_xm, pic_last, pic_mem_last_valid, wgt_last, wgt_mem_last_valid,
                           bias_last, bias_mem_last_valid, bias_mem_data[DW-1:8]};

  always_comb begin
    state_d   = state_q;
    addrx_d   = addrx_q;
    addrb_d   = addrb_q;
    addrz_d   = addrz_q;
    wrow_d    = wrow_q;
    ym_d      = ym_q;
    yn_d      = yn_q;
    bn_d      = bn_q;
    row_d     = row_q;
    cofs_d    = cofs_q;
    acc_d     = acc_q;
    pic_buf_d = pic_buf_q;
    wgt_buf_d = wgt_buf_q;
    pic_got_d = pic_got_q;
    wgt_got_d = wgt_got_q;
    res_d     = res_q;
    case (state_q)
      S_IDLE: if (fc_go) begin
        addrx_d   = fc_addrx;
        addrb_d   = fc_addrb;
        addrz_d   = fc_addrz;
        wrow_d    = fc_addry;
        ym_d      = fc_ym;
        yn_d      = fc_yn;
        bn_d      = cnn_bn;
        row_d     = '0;
        cofs_d    = '0;
        acc_d     = '0;
        pic_got_d = 1'b0;
        wgt_got_d = 1'b0;
        state_d   = (fc_ym == '0) ? S_DONE : S_BIAS;
      end
      S_BIAS: if (!bias_need_w || bias_mem_valid) begin
        acc_d   = bias_need_w ? {{24{bias_mem_data[7]}}, bias_mem_data[7:0]} : '0;
        state_d = (yn_q == '0) ? S_WRITE : S_DATA;
      end
      S_DATA: begin
        if (pic_mem_req && pic_mem_valid) begin
          pic_buf_d = pic_mem_data;
          pic_got_d = 1'b1;
        end
        if (wgt_mem_req && wgt_mem_valid) begin
          wgt_buf_d = wgt_mem_data;
          wgt_got_d = 1'b1;
        end
        if (pic_got_d && wgt_got_d) state_d = S_MAC;
      end
      S_MAC: begin
        acc_d     = acc_q + mac_chunk(pic_buf_q, wgt_buf_q, chunk_sz_w);
        pic_got_d = 1'b0;
        wgt_got_d = 1'b0;
        if (cofs_q + CW'(CHUNK_BYTES) >= {1'b0, yn_q}) begin
          state_d = S_WRITE;
        end else begin
          cofs_d  = cofs_q + CW'(CHUNK_BYTES);
          state_d = S_DATA;
        end
      end
      S_WRITE: if (wr_mem_ack) begin
        row_d   = row_q + DIM_W'(1);
        cofs_d  = '0;
        wrow_d  = wrow_q + ADDR_WIDTH'(yn_q);
        acc_d   = '0;
        state_d = (row_q + DIM_W'(1) == ym_q) ? S_DONE : S_BIAS;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Result byte is frozen on WRITE entry so the write beat stays stable until acknowledged.
    if (state_d == S_WRITE && state_q != S_WRITE) res_d = to_byte(acc_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addrx_q   <= '0;
      addrb_q   <= '0;
      addrz_q   <= '0;
      wrow_q    <= '0;
      ym_q      <= '0;
      yn_q      <= '0;
      bn_q      <= '0;
      row_q     <= '0;
      cofs_q    <= '0;
      acc_q     <= '0;
      pic_buf_q <= '0;
      wgt_buf_q <= '0;
      pic_got_q <= 1'b0;
      wgt_got_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      addrx_q   <= addrx_d;
      addrb_q   <= addrb_d;
      addrz_q   <= addrz_d;
      wrow_q    <= wrow_d;
      ym_q      <= ym_d;
      yn_q      <= yn_d;
      bn_q      <= bn_d;
      row_q     <= row_d;
      cofs_q    <= cofs_d;
      acc_q     <= acc_d;
      pic_buf_q <= pic_buf_d;
      wgt_buf_q <= wgt_buf_d;
      pic_got_q <= pic_got_d;
      wgt_got_q <= wgt_got_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_fcc.sv
// Bench for fcc: byte-addressed memory model answering the three read ports and the write port,
// with results compared against a dot-product reference computed directly from memory contents.
module tb_fcc;

  localparam int AW = 19;
  localparam int X0 = 'h01003;
  localparam int W0 = 'h20011;
  localparam int B0 = 'h00305;
  localparam int Z0 = 'h4000A;

  typedef struct {int port; int addr; int size;} grant_t;
  typedef struct {int addr; logic [255:0] data; int size; logic last; logic [4:0] lv;} wrec_t;

  logic clk = 1'b0;
  logic rst, fc_go;
  logic [AW-1:0] fc_addrx, fc_addry, fc_addrb, fc_addrz;
  logic [7:0] fc_xm, fc_ym, fc_yn, cnn_bn;
  logic busy, done;
  logic pic_req, wgt_req, bias_req, wr_req;
  logic [AW-1:0] pic_addr, wgt_addr, bias_addr, wr_addr;
  logic [5:0] pic_size, wgt_size, bias_size, wr_size;
  logic [2:0] vld;
  logic [255:0] rdat [3];
  logic [255:0] wr_data;
  logic wr_lst;
  logic [4:0] wr_lv;
  logic wr_ack;

  logic [2:0] rq;
  logic [AW-1:0] ra [3];
  logic [5:0] rs [3];
  assign rq = {bias_req, wgt_req, pic_req};
  assign ra[0] = pic_addr;  assign ra[1] = wgt_addr;  assign ra[2] = bias_addr;
  assign rs[0] = pic_size;  assign rs[1] = wgt_size;  assign rs[2] = bias_size;

  logic [7:0] mem [0:(1<<AW)-1];
  grant_t grants[$];
  wrec_t  wrs[$];
  int n_assert = 0;
  int n_fail = 0;

  fcc dut (
    .clk(clk), .rst(rst), .fc_go(fc_go),
    .fc_addrx(fc_addrx), .fc_addry(fc_addry), .fc_addrb(fc_addrb), .fc_addrz(fc_addrz),
    .fc_xm(fc_xm), .fc_ym(fc_ym), .fc_yn(fc_yn), .cnn_bn(cnn_bn),
    .fc_sw_busy_ind(busy), .fc_done(done),
    .pic_mem_req(pic_req), .pic_mem_start_addr(pic_addr), .pic_mem_size_bytes(pic_size),
    .pic_mem_valid(vld[0]), .pic_mem_data(rdat[0]), .pic_last(1'b0), .pic_mem_last_valid(5'd0),
    .wgt_mem_req(wgt_req), .wgt_mem_start_addr(wgt_addr), .wgt_mem_size_bytes(wgt_size),
    .wgt_mem_valid(vld[1]), .wgt_mem_data(rdat[1]), .wgt_last(1'b0), .wgt_mem_last_valid(5'd0),
    .bias_mem_req(bias_req), .bias_mem_start_addr(bias_addr), .bias_mem_size_bytes(bias_size),
    .bias_mem_valid(vld[2]), .bias_mem_data(rdat[2]), .bias_last(1'b1), .bias_mem_last_valid(5'd1),
    .wr_mem_req(wr_req), .wr_mem_start_addr(wr_addr), .wr_mem_size_bytes(wr_size),
    .wr_mem_data(wr_data), .wr_last(wr_lst), .wr_mem_last_valid(wr_lv), .wr_mem_ack(wr_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read responders: random latency, valid held up to 3 cycles, withdrawn when a fresh request appears.
  int st [3], wt [3], hold [3];
  bit seen_low [3];
  logic [AW-1:0] req_a [3];
  always @(negedge clk) begin
    if (rst) begin
      vld = '0;
      for (int p = 0; p < 3; p++) st[p] = 0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        case (st[p])
          0: if (rq[p]) begin req_a[p] = ra[p]; wt[p] = $urandom_range(0, 2); st[p] = 1; end
          1: begin
            check($sformatf("req_held_p%0d", p), rq[p], 1'b1);
            check($sformatf("addr_stable_p%0d", p), ra[p], req_a[p]);
            if (wt[p] == 0) begin
              for (int i = 0; i < 32; i++)
                rdat[p][8*i +: 8] = (i < int'(rs[p])) ? mem[int'(ra[p]) + i] : 8'h55;
              grants.push_back('{p, int'(ra[p]), int'(rs[p])});
              vld[p] = 1'b1; hold[p] = 3; seen_low[p] = 1'b0; st[p] = 2;
            end else wt[p]--;
          end
          default: begin
            if (hold[p] == 3) check($sformatf("req_drop_p%0d", p), rq[p], 1'b0);
            if (!rq[p]) seen_low[p] = 1'b1;
            hold[p]--;
            if (seen_low[p] && rq[p]) begin
              vld[p] = 1'b0; req_a[p] = ra[p]; wt[p] = $urandom_range(0, 2); st[p] = 1;
            end else if (hold[p] == 0) begin
              vld[p] = 1'b0; st[p] = 0;
            end
          end
        endcase
      end
    end
  end

  // Write responder: acknowledge 5 cycles after the request appears.
  bit wact; int wcnt; logic [AW-1:0] wa0; logic [255:0] wd0;
  always @(negedge clk) begin
    if (rst) begin
      wr_ack = 1'b0; wact = 1'b0;
    end else if (wr_ack) begin
      wr_ack = 1'b0; wact = 1'b0;
      check("wr_req_drop", wr_req, 1'b0);
    end else if (wr_req) begin
      if (!wact) begin
        wact = 1'b1; wcnt = 0; wa0 = wr_addr; wd0 = wr_data;
      end else begin
        check("wr_addr_stable", wr_addr, wa0);
        check("wr_data_stable", wr_data, wd0);
      end
      wcnt++;
      if (wcnt == 5) begin
        wr_ack = 1'b1;
        wrs.push_back('{int'(wr_addr), wr_data, int'(wr_size), wr_lst, wr_lv});
      end
    end
  end

  function automatic logic [7:0] ref_z(input int r, input int yn_v, input int bn_v);
    int acc;
    byte xa, wb;
    acc = 0;
    if (r < bn_v) begin xa = mem[B0 + r]; acc = int'(xa); end
    for (int k = 0; k < yn_v; k++) begin
      xa = mem[X0 + k];
      wb = mem[W0 + r*yn_v + k];
      acc += int'(xa) * int'(wb);
    end
    acc = acc >>> 8;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
`ifdef FCC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc[7:0];
  endfunction

  task automatic fill(input bit rnd, input int xv, input int wv, input int bv);
    for (int k = 0; k < 256; k++) mem[X0 + k] = rnd ? 8'($urandom) : 8'(xv);
    for (int k = 0; k < 128*128; k++) mem[W0 + k] = rnd ? 8'($urandom) : 8'(wv);
    for (int k = 0; k < 256; k++) mem[B0 + k] = rnd ? 8'($urandom) : 8'(bv);
  endtask

  task automatic verify(input int yn_v, input int ym_v, input int bn_v, input int reps);
    grant_t e[$], a[$];
    int n;
    for (int p = 0; p < 3; p++) begin
      e.delete(); a.delete();
      for (int rep = 0; rep < reps; rep++)
        for (int r = 0; r < ym_v; r++) begin
          if (p == 2 && r < bn_v) e.push_back('{2, B0 + r, 1});
          for (int c = 0; p < 2 && 32*c < yn_v; c++)
            e.push_back('{p, (p == 0) ? X0 + 32*c : W0 + r*yn_v + 32*c,
                          (yn_v - 32*c > 32) ? 32 : yn_v - 32*c});
        end
      foreach (grants[i]) if (grants[i].port == p) a.push_back(grants[i]);
      check($sformatf("grant_count_p%0d", p), a.size(), e.size());
      n = (a.size() < e.size()) ? a.size() : e.size();
      for (int i = 0; i < n; i++) begin
        check($sformatf("grant_addr_p%0d_%0d", p, i), a[i].addr, e[i].addr);
        check($sformatf("grant_size_p%0d_%0d", p, i), a[i].size, e[i].size);
      end
    end
    check("write_count", wrs.size(), reps*ym_v);
    n = (wrs.size() < reps*ym_v) ? wrs.size() : reps*ym_v;
    for (int i = 0; i < n; i++) begin
      check($sformatf("wr_addr_%0d", i), wrs[i].addr, Z0 + i % ym_v);
      check($sformatf("z_%0d", i), wrs[i].data, {248'd0, ref_z(i % ym_v, yn_v, bn_v)});
      check($sformatf("wr_size_%0d", i), wrs[i].size, 1);
      check($sformatf("wr_last_%0d", i), {wrs[i].last, wrs[i].lv}, 6'b100000);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
    check({tag, "_seen"}, done, 1'b1);
    @(negedge clk);
    check({tag, "_pulse"}, done, 1'b0);
  endtask

  task automatic run_op(input int yn_v, input int ym_v, input int bn_v, input bit hold_go);
    int n = 0;
    grants.delete(); wrs.delete();
    @(negedge clk);
    fc_addrx = AW'(X0); fc_addry = AW'(W0); fc_addrb = AW'(B0); fc_addrz = AW'(Z0);
    fc_yn = 8'(yn_v); fc_xm = 8'(yn_v); fc_ym = 8'(ym_v); cnn_bn = 8'(bn_v);
    fc_go = 1'b1;
    @(negedge clk);
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("busy_start", busy, 1'b1);
    if (!hold_go) begin
      fc_go = 1'b0;
      fc_addrx = AW'($urandom); fc_addry = AW'($urandom); fc_addrb = AW'($urandom);
      fc_addrz = AW'($urandom); fc_yn = 8'($urandom); fc_ym = 8'($urandom); cnn_bn = 8'($urandom);
    end
    wait_done("done");
    if (hold_go) begin
      @(negedge clk);
      check("restart_busy", busy, 1'b1);
      fc_go = 1'b0;
      wait_done("done2");
    end
    check("idle_after", busy, 1'b0);
    verify(yn_v, ym_v, bn_v, hold_go ? 2 : 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; fc_go = 1'b0; wr_ack = 1'b0; vld = '0;
    fc_addrx = '0; fc_addry = '0; fc_addrb = '0; fc_addrz = '0;
    fc_xm = '0; fc_ym = '0; fc_yn = '0; cnn_bn = '0;
    for (int p = 0; p < 3; p++) rdat[p] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_reqs", {pic_req, wgt_req, bias_req, wr_req}, 4'b0);
    check("rst_addrs", {pic_addr, wgt_addr, bias_addr, wr_addr}, '0);
    check("rst_sizes", {pic_size, wgt_size, bias_size, wr_size}, '0);
    check("rst_wr_data", wr_data, '0);
    check("rst_wr_last", {wr_lst, wr_lv}, 6'b0);
    rst = 1'b0;

    fill(1'b0, 2, 3, 9);
    run_op(128, 1, 1, 1'b0);
    if (wrs.size() > 0) check("z_basic", wrs[0].data[7:0], 8'd3);
    run_op(128, 128, 128, 1'b0);

    fill(1'b0, 127, 127, 0);
    run_op(128, 1, 1, 1'b0);
    if (wrs.size() > 0) check("sat_pos", wrs[0].data[7:0], 8'h7f);
    fill(1'b0, -128, 127, 0);
    run_op(128, 1, 1, 1'b0);
`ifdef FCC_RELU_EN
    if (wrs.size() > 0) check("sat_neg", wrs[0].data[7:0], 8'h00);
`else
    if (wrs.size() > 0) check("sat_neg", wrs[0].data[7:0], 8'h80);
`endif

    fill(1'b1, 0, 0, 0);
    run_op(40, 3, 2, 1'b0);
    run_op(0, 3, 2, 1'b0);
    run_op(64, 0, 0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      fill(1'b1, 0, 0, 0);
      run_op($urandom_range(1, 80), $urandom_range(1, 4), $urandom_range(0, 5), 1'b0);
    end
    run_op(8, 2, 1, 1'b1);

    // Abort in the middle of a chunk fetch.
    grants.delete(); wrs.delete();
    @(negedge clk);
    fc_addrx = AW'(X0); fc_addry = AW'(W0); fc_addrb = AW'(B0); fc_addrz = AW'(Z0);
    fc_yn = 8'd64; fc_xm = 8'd64; fc_ym = 8'd2; cnn_bn = 8'd2; fc_go = 1'b1;
    n = 0;
    while (pic_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("reach_data", pic_req, 1'b1);
    fc_go = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_reqs", {pic_req, wgt_req, bias_req, wr_req}, 4'b0);
    check("abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_stays_idle", {busy, pic_req, wgt_req, bias_req, wr_req}, 5'b0);
    check("abort_no_write", wrs.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
